// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller that sequences a multi-cycle SRAM access and stalls
// the pipeline while the access is in flight.
//
// Operation: an op seen in IDLE is registered and freezes the pipeline in that
// same cycle. ACCESS then lasts WAIT_STATES cycles, and DONE releases freeze for
// one cycle while presenting the load result. A memory op therefore holds
// freeze for WAIT_STATES+1 cycles and occupies the stage for WAIT_STATES+2.
//
// Optional feature (macro MEM_ALIGN_CHECK_EN):
//   defined   - an op whose ALU_result[1:0] != 0 is dropped in IDLE and
//               align_err pulses for exactly the following cycle.
//   undefined - the low address bits are ignored and align_err is tied low.
//
// Parameters:
//   ADDRESS_LEN  datapath word width
//   SRAM_AW      SRAM word-address width
//   WAIT_STATES  SRAM access cycles (1..15)
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   MEM_read     load request (EXE/MEM register)
//   MEM_write    store request (EXE/MEM register)
//   ALU_result   byte address
//   ST_value     store data
//   sram_rdata   SRAM read data, valid in the last access cycle
//   sram_en      SRAM access strobe
//   sram_we      SRAM write enable
//   sram_addr    SRAM word address (registered ALU_result[SRAM_AW+1:2])
//   sram_wdata   registered store data
//   MEM_out      load result, non-zero only in DONE
//   freeze       pipeline stall
//   align_err    misaligned-access pulse
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int ADDRESS_LEN = 32,
    parameter int SRAM_AW     = 16,
    parameter int WAIT_STATES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_read,
    input  logic                   MEM_write,
    input  logic [ADDRESS_LEN-1:0] ALU_result,
    input  logic [ADDRESS_LEN-1:0] ST_value,
    input  logic [ADDRESS_LEN-1:0] sram_rdata,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [ADDRESS_LEN-1:0] sram_wdata,
    output logic [ADDRESS_LEN-1:0] MEM_out,
    output logic                   freeze,
    output logic                   align_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(WAIT_STATES - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_next;
    logic [SRAM_AW-1:0]     r_addr;
    logic [ADDRESS_LEN-1:0] r_wdata;
    logic [ADDRESS_LEN-1:0] r_data;
    logic                   r_we;

    logic                   w_op;
    logic                   w_misaligned;
    logic                   w_start;
    logic                   w_latch;
    logic                   w_freeze;
    logic                   w_sram_en;
    logic [ADDRESS_LEN-1:0] w_mem_out;
    logic                   w_align_pulse;

    // Only a slice of the byte address is used for the word address.
    logic                   w_unused_addr_bits;
    assign w_unused_addr_bits = ^ALU_result;

    assign w_op = MEM_read | MEM_write;

`ifdef MEM_ALIGN_CHECK_EN
    logic r_align_err;

    assign w_misaligned = |ALU_result[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_align_pulse;
        end
    end

    assign align_err = r_align_err;
`else
    assign w_misaligned = 1'b0;
    assign align_err    = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_start       = 1'b0;
        w_latch       = 1'b0;
        w_freeze      = 1'b0;
        w_sram_en     = 1'b0;
        w_mem_out     = '0;
        w_align_pulse = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_op) begin
                    if (w_misaligned) begin
                        w_align_pulse = 1'b1;
                    end else begin
                        w_start      = 1'b1;
                        w_freeze     = 1'b1;
                        w_cnt_next   = 4'd0;
                        w_state_next = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                w_sram_en  = 1'b1;
                w_freeze   = 1'b1;
                w_cnt_next = r_cnt + 4'd1;
                if (r_cnt == LP_LAST) begin
                    w_latch      = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_mem_out    = r_data;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_start) begin
                r_addr  <= ALU_result[SRAM_AW+1:2];
                r_wdata <= ST_value;
                // A write wins when both requests are raised together.
                r_we    <= MEM_write;
            end
            if (w_latch) begin
                // Stores leave a zero result so MEM_out stays 0 in DONE.
                r_data <= r_we ? '0 : sram_rdata;
            end
        end
    end

    // Outputs are forced low while reset is asserted, including the cycle in
    // which a reset lands on an in-flight access.
    assign sram_en    = w_sram_en & ~rst;
    assign sram_we    = w_sram_en & r_we & ~rst;
    assign freeze     = w_freeze & ~rst;
    assign MEM_out    = rst ? '0 : w_mem_out;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam int WS = 3;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_read = 1'b0;
    logic        MEM_write = 1'b0;
    logic [31:0] ALU_result = '0;
    logic [31:0] ST_value = '0;
    logic [31:0] sram_rdata = '0;
    logic        sram_en;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] MEM_out;
    logic        freeze;
    logic        align_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_ctrl #(
        .ADDRESS_LEN(32),
        .SRAM_AW    (16),
        .WAIT_STATES(WS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_read  (MEM_read),
        .MEM_write (MEM_write),
        .ALU_result(ALU_result),
        .ST_value  (ST_value),
        .sram_rdata(sram_rdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .MEM_out   (MEM_out),
        .freeze    (freeze),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge so new inputs can be driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".freeze"},  32'(freeze),  32'd0);
        check({tag, ".sram_en"}, 32'(sram_en), 32'd0);
        check({tag, ".sram_we"}, 32'(sram_we), 32'd0);
        check({tag, ".mem_out"}, MEM_out,      32'd0);
    endtask

    task automatic idle_cycle();
        next_cycle();
        MEM_read   = 1'b0;
        MEM_write  = 1'b0;
        ALU_result = $urandom;
        ST_value   = $urandom;
        sram_rdata = $urandom;
        @(negedge clk);
        check_quiet("idle");
        check("idle.align_err", 32'(align_err), 32'd0);
    endtask

    // One memory op as the pipeline would present it: inputs appear in the
    // IDLE cycle and stay asserted while frozen. The expected waveform comes
    // straight from the cycle index within the op.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] last_rdata,
                         input bit perturb);
        logic [31:0] exp_out;
        logic [15:0] exp_addr;
        bit          misaligned;
        misaligned = ALIGN_CHK && (addr[1:0] != 2'b00);
        exp_addr   = addr[17:2];
        exp_out    = wr ? 32'd0 : last_rdata;

        next_cycle();
        MEM_read   = rd;
        MEM_write  = wr;
        ALU_result = addr;
        ST_value   = data;
        sram_rdata = $urandom;
        @(negedge clk);
        check("req.align_err", 32'(align_err), 32'd0);
        check("req.sram_en", 32'(sram_en), 32'd0);
        check("req.mem_out", MEM_out, 32'd0);
        if (misaligned) begin
            check("mis.freeze", 32'(freeze), 32'd0);
            next_cycle();
            MEM_read  = 1'b0;
            MEM_write = 1'b0;
            @(negedge clk);
            check("mis.align_err", 32'(align_err), 32'd1);
            check_quiet("mis.after");
            $display("[TB] op rd=%0b wr=%0b addr=0x%08h misaligned -> dropped", rd, wr, addr);
            return;
        end
        check("req.freeze", 32'(freeze), 32'd1);

        for (int k = 1; k <= WS; k++) begin
            next_cycle();
            if (perturb) begin
                ALU_result = $urandom;
                ST_value   = $urandom;
            end
            sram_rdata = (k == WS) ? last_rdata : $urandom;
            @(negedge clk);
            check("acc.sram_en",    32'(sram_en),   32'd1);
            check("acc.sram_we",    32'(sram_we),   32'(wr));
            check("acc.freeze",     32'(freeze),    32'd1);
            check("acc.sram_addr",  32'(sram_addr), 32'(exp_addr));
            check("acc.sram_wdata", sram_wdata,     data);
            check("acc.mem_out",    MEM_out,        32'd0);
        end

        next_cycle();
        sram_rdata = $urandom;
        @(negedge clk);
        check("done.freeze",  32'(freeze),  32'd0);
        check("done.sram_en", 32'(sram_en), 32'd0);
        check("done.mem_out", MEM_out,      exp_out);
        $display("[TB] op rd=%0b wr=%0b addr=0x%08h word=0x%04h wdata=0x%08h exp_out=0x%08h got=0x%08h",
                 rd, wr, addr, exp_addr, data, exp_out, MEM_out);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("rst");
        check("rst.align_err",  32'(align_err),  32'd0);
        check("rst.sram_addr",  32'(sram_addr),  32'd0);
        check("rst.sram_wdata", sram_wdata,      32'd0);
        next_cycle();
        rst = 1'b0;

        // Non-memory stream
        repeat (4) idle_cycle();

        // Directed load and store
        do_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        idle_cycle();
        do_op(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, $urandom, 1'b1);
        idle_cycle();

        // Back-to-back loads, then both requests high
        do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_0001, 1'b1);
        do_op(1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'h5A5A_0002, 1'b1);
        do_op(1'b1, 1'b1, 32'h0000_0308, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0);

        // Misaligned load: dropped with the check, a normal access without it
        do_op(1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'h0BAD_F00D, 1'b0);
        idle_cycle();

        // Reset in the second ACCESS cycle aborts the access
        next_cycle();
        MEM_read   = 1'b1;
        ALU_result = 32'h0000_0040;
        @(negedge clk);
        check("abort.req_freeze", 32'(freeze), 32'd1);
        next_cycle();
        @(negedge clk);
        check("abort.acc1_en", 32'(sram_en), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        next_cycle();
        rst      = 1'b0;
        MEM_read = 1'b0;
        @(negedge clk);
        check_quiet("abort.after");
        check("abort.sram_addr",  32'(sram_addr), 32'd0);
        check("abort.sram_wdata", sram_wdata,     32'd0);
        idle_cycle();
        $display("[TB] reset during access -> aborted");
        do_op(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h1111_2222, 1'b0);

        // Randomized ops with random gaps
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            do_op(sel != 1, sel >= 1, $urandom, $urandom, $urandom, 1'b1);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
